// File: rtl/lfsr_parity_pkg.sv
// Shared LFSR/parity definitions for the tt_um_lfsr_parity transmitter and its receive-side checker.
package lfsr_parity_pkg;

  localparam int unsigned LFSR_W = 7;
  localparam int unsigned TAP_A  = 6;
  localparam int unsigned TAP_B  = 5;

  typedef enum logic {
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  // Fibonacci step for x^7 + x^6 + 1: shift left, feed back s[6]^s[5] into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction

  // Parity bit that makes the whole 8-bit word even.
  function automatic logic word_parity(input logic [LFSR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/lfsr_parity_checker.sv
// Receive-side checker: self-synchronises to the LFSR word stream, checks parity,
// flags sequence and illegal-state errors, and reports lock plus error/word counts.
module lfsr_parity_checker
  import lfsr_parity_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             parity_err,
  output logic             zero_err,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      word_count
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_COUNT);

  state_t            state;
  logic              seeded;
  logic [MW-1:0]     match_cnt;
  logic [LW-1:0]     miss_cnt;
  logic [LFSR_W-1:0] expected;

  logic [LFSR_W-1:0] field;
  logic              p_bad;
  logic              z_bad;
  logic              s_bad;
  logic              any_bad;

  always_comb begin
    field   = data_in[LFSR_W-1:0];
    p_bad   = data_in[7] != word_parity(field);
    z_bad   = field == '0;
    s_bad   = (state == ST_LOCKED) && (field != expected);
    any_bad = p_bad || z_bad || s_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACQUIRE;
      seeded     <= 1'b0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      expected   <= '0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      parity_err <= 1'b0;
      zero_err   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      seq_err    <= 1'b0;
      parity_err <= 1'b0;
      zero_err   <= 1'b0;
      if (data_valid) begin
        word_count <= word_count + 16'd1;
        parity_err <= p_bad;
        zero_err   <= z_bad;
        if (any_bad && (err_count != '1)) begin
          err_count <= err_count + 1'b1;
        end
        case (state)
          ST_ACQUIRE: begin
            // Zero words are never a valid seed or successor, so acquisition ignores them.
            if (!z_bad) begin
              expected <= lfsr_next(field);
              if (!seeded || (field != expected)) begin
                seeded    <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
                if ((match_cnt + 1'b1) == LOCK_MAX) begin
                  state    <= ST_LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end
              end
            end
          end
          ST_LOCKED: begin
            // Flywheel: the local sequence advances regardless of what was received.
            expected <= lfsr_next(expected);
            seq_err  <= s_bad;
            if (!s_bad) begin
              miss_cnt <= '0;
            end else if ((miss_cnt + 1'b1) == LOSS_MAX) begin
              state     <= ST_ACQUIRE;
              locked    <= 1'b0;
              seeded    <= 1'b0;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          default: begin
            state  <= ST_ACQUIRE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Directed bench for lfsr_parity_checker; ERR_W is narrowed so saturation is reachable.
module tb_lfsr_parity_checker;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        locked;
  logic        seq_err;
  logic        parity_err;
  logic        zero_err;
  logic [2:0]  err_count;
  logic [15:0] word_count;

  int checks;
  int failures;

  lfsr_parity_checker #(
    .LOCK_COUNT(4),
    .LOSS_COUNT(3),
    .ERR_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
    .locked(locked),
    .seq_err(seq_err),
    .parity_err(parity_err),
    .zero_err(zero_err),
    .err_count(err_count),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] w);
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_zero_err", zero_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);
    rst = 1'b0;

    // Acquire on states 01,02,04,08,10
    send(8'h81);
    chk("acq1_locked", locked, 0);
    send(8'h82);
    send(8'h84);
    send(8'h88);
    chk("acq4_locked", locked, 0);
    send(8'h90);
    chk("acq5_locked", locked, 1);
    chk("acq5_word_count", word_count, 5);
    chk("acq5_err_count", err_count, 0);
    chk("acq5_seq_err", seq_err, 0);
    chk("acq5_parity_err", parity_err, 0);

    // Expected 20: send with parity bit cleared
    send(8'h20);
    chk("par_parity_err", parity_err, 1);
    chk("par_seq_err", seq_err, 0);
    chk("par_err_count", err_count, 1);
    chk("par_locked", locked, 1);
    send(8'h41);
    chk("par_pulse_end", parity_err, 0);

    // Expected 03: substitute valid state 05, then resume at 06
    send(8'h05);
    chk("miss1_seq_err", seq_err, 1);
    chk("miss1_err_count", err_count, 2);
    chk("miss1_locked", locked, 1);
    send(8'h06);
    chk("resume_seq_err", seq_err, 0);
    chk("resume_locked", locked, 1);

    // Three consecutive wrong words in place of 0C,18,30
    send(8'h03);
    chk("loss1_seq_err", seq_err, 1);
    chk("loss1_locked", locked, 1);
    send(8'h03);
    chk("loss2_seq_err", seq_err, 1);
    chk("loss2_locked", locked, 1);
    send(8'h03);
    chk("loss3_seq_err", seq_err, 1);
    chk("loss3_locked", locked, 0);
    chk("loss3_err_count", err_count, 5);
    chk("loss3_word_count", word_count, 12);

    // Relock on E1(61),42,05,0A,14
    send(8'hE1);
    send(8'h42);
    send(8'h05);
    send(8'h0A);
    chk("relock4_locked", locked, 0);
    chk("relock4_seq_err", seq_err, 0);
    send(8'h14);
    chk("relock5_locked", locked, 1);
    chk("relock5_word_count", word_count, 17);
    chk("relock5_err_count", err_count, 5);

    // Zero word while locked (expected 28)
    send(8'h00);
    chk("lz_zero_err", zero_err, 1);
    chk("lz_seq_err", seq_err, 1);
    chk("lz_parity_err", parity_err, 0);
    chk("lz_err_count", err_count, 6);
    chk("lz_locked", locked, 1);
    send(8'hD1);
    chk("lz_next_seq_err", seq_err, 0);
    chk("lz_next_zero_err", zero_err, 0);

    // Gaps of 1..3 idle cycles
    send(8'hA3);
    idle(1);
    chk("gap1_seq_err", seq_err, 0);
    send(8'h47);
    idle(3);
    chk("gap3_word_count", word_count, 21);
    chk("gap3_locked", locked, 1);
    send(8'h0F);
    idle(2);
    chk("gap2_zero_err", zero_err, 0);
    send(8'h1E);
    chk("gap_end_seq_err", seq_err, 0);
    chk("gap_end_locked", locked, 1);
    chk("gap_end_word_count", word_count, 23);
    chk("gap_end_err_count", err_count, 6);

    // One-cycle reset while locked
    rst        = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_locked", locked, 0);
    chk("rst2_err_count", err_count, 0);
    chk("rst2_word_count", word_count, 0);

    // Zero words in ACQUIRE, both unseeded and mid-acquisition
    send(8'h00);
    chk("az_zero_err", zero_err, 1);
    chk("az_seq_err", seq_err, 0);
    chk("az_err_count", err_count, 1);
    chk("az_locked", locked, 0);
    send(8'h81);
    chk("az_next_zero_err", zero_err, 0);
    send(8'h82);
    send(8'h00);
    chk("az2_zero_err", zero_err, 1);
    send(8'h84);
    send(8'h88);
    chk("az_acq_locked", locked, 0);
    send(8'h90);
    chk("az_lock_locked", locked, 1);
    chk("az_lock_err_count", err_count, 2);
    chk("az_lock_word_count", word_count, 7);

    // Saturate the 3-bit error counter
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("sat3_locked", locked, 0);
    chk("sat3_err_count", err_count, 5);
    send(8'h00);
    send(8'h00);
    chk("sat5_err_count", err_count, 7);
    send(8'h00);
    chk("sat6_err_count", err_count, 7);
    chk("sat6_word_count", word_count, 13);

    data_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_parity_checker.md
Name: lfsr_parity_checker

Overview:
Receive-side checker for the 8-bit LFSR/parity word stream produced by tt_um_lfsr_parity.
- Each valid word carries a 7-bit LFSR state in [6:0] and a parity bit in [7].
- The block self-synchronises to the LFSR sequence and checks every word's parity.
- Sequence mismatches and illegal words are flagged; lock status and error/word counters are reported.
- Sits at the far end of the link, e.g. in a bench or a loopback tile.

Parameters:
LOCK_COUNT, 4, consecutive correct successor words after the seed word needed to declare lock (≥1)
LOSS_COUNT, 3, consecutive sequence mismatches while locked that drop lock (≥1)
ERR_W, 16, width of saturating error counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
data_in  in  8  [6:0] LFSR state, [7] parity bit
data_valid  in  1  data_in is sampled on this cycle's rising edge only when high
locked  out  1  high while in LOCKED state
seq_err  out  1  one-cycle pulse: valid word ≠ expected LFSR state while locked
parity_err  out  1  one-cycle pulse: data_in[7] ≠ ^data_in[6:0]
zero_err  out  1  one-cycle pulse: data_in[6:0] == 0 (illegal LFSR state)
err_count  out  ERR_W  erroneous valid words, saturating at all-ones
word_count  out  16  valid words received, wraps modulo 2^16

Behaviour:
- LFSR definition: 7-bit Fibonacci, polynomial x^7+x^6+1, next(s) = {s[5:0], s[6]^s[5]}. Period 127 for any nonzero seed.
- Parity is even over all 8 bits: expected data_in[7] = ^data_in[6:0].
- All outputs are registered. Flags and counters update on the clock edge that samples the valid word; they are visible in the following cycle (1-cycle latency).
- Reset (rst=1 at clk edge): all outputs 0, state ACQUIRE, seeded=0, match_cnt=0, miss_cnt=0, expected=0. Reset mid-operation discards lock and all counts immediately.
- data_valid=0: state, expected and counters hold; all pulse outputs are 0.
- Checks applied to every valid word in every state:
  - parity_err and zero_err are evaluated independently.
  - err_count increments by exactly 1 per valid word having any of parity_err, zero_err or seq_err, even if several coincide. It holds at max.
  - word_count increments on every valid word.
- State ACQUIRE (locked=0):
  - Zero word: zero_err pulses; seeded, expected and match_cnt are unchanged.
  - seeded=0 and nonzero word: expected←next(word), seeded←1, match_cnt←0.
  - seeded=1 and word==expected: match_cnt++, expected←next(word). If match_cnt reaches LOCK_COUNT, go to LOCKED and set miss_cnt←0.
  - seeded=1 and nonzero word≠expected: re-seed from this word (expected←next(word)), match_cnt←0. No seq_err in ACQUIRE.
  - Parity errors do not block acquisition; the LFSR field alone is compared.
- State LOCKED (locked=1):
  - word[6:0]==expected: miss_cnt←0.
  - Otherwise (zero words included): seq_err pulses and miss_cnt++.
  - expected←next(expected) in both cases (flywheel; the received word is never used to resync).
  - If miss_cnt reaches LOSS_COUNT: go to ACQUIRE with seeded=0 and match_cnt=0; locked falls the next cycle.
- Timing with defaults: word 1 seeds, words 2–5 match, locked=1 in the cycle after word 5 is sampled.

Decomposition:
- Package lfsr_parity_pkg holds:
  - LFSR_W=7 and the tap positions 6 and 5;
  - state enum {ST_ACQUIRE, ST_LOCKED};
  - function lfsr_next(s);
  - function word_parity(d).
- The transmitter uses the same package so both ends stay consistent.
- No sub-module is needed; a single module with a 2-state FSM, the match/miss counters and the output registers.

Test Plan:
- Reset, then contiguous valid words 0x81,0x82,0x84,0x88,0x90 (states 01,02,04,08,10) → locked=1 the cycle after 0x90; seq_err, parity_err, err_count all 0; word_count=5.
- Locked, send 0x20 with parity bit flipped (0x20 instead of 0xA0) → parity_err pulses once, err_count=1, locked stays 1, no seq_err.
- Locked, replace one word with a wrong valid state, then resume the correct sequence → one seq_err pulse, err_count+1, miss_cnt clears, locked stays 1.
- Locked, inject 3 consecutive wrong words → 3 seq_err pulses, locked=0 after the third; correct stream afterwards → relock after 1+LOCK_COUNT words.
- Word 0x00 in ACQUIRE → zero_err pulses, err_count+1, the next nonzero word still seeds. Word 0x00 in LOCKED → zero_err and seq_err in the same cycle, err_count +1 only.
- Valid stream with data_valid=0 gaps of 1–3 cycles, plus rst asserted for 1 cycle while locked → gaps don't affect lock or counts; reset clears locked, err_count and word_count to 0 the next cycle.
